step_phase_decoder: RTL
=======================

// Module: step_phase_decoder
// PURPOSE
//  Receive-side decoder for the two-phase stepper coil bus (B' A' B A) produced by the cutting motor driver.
//  Samples phase_i on the 50 MHz system clock, filters glitches, and classifies each accepted pattern change as a forward step, reverse step or illegal jump.
//  Tracks signed position and counts completed cut strokes (out leg then return leg) for the kitchen controller.
// PARAMETERS
//  STEPS_PER_STROKE  100        steps per leg (100 x 0.9 deg = 90 deg)
//  POS_W             16         width of pos_o, two's complement
//  STABLE_CYCLES     4          consecutive equal samples before a pattern is accepted (>=1)
//  OUT_DIR           0          dir value of the out leg of a stroke
//  TIMEOUT_CYC       2000000    stall threshold in clk cycles (macro only)
// PORTS
//  clk            in   1      system clock, 50 MHz
//  rst_n          in   1      synchronous, active-low reset
//  phase_i        in   4      coil pattern {B',A',B,A}, asynchronous to clk
//  clr_i          in   1      synchronous clear of pos/stroke/err state
//  pos_o          out  POS_W  signed step position
//  dir_o          out  1      direction of last valid step (1 = 3->6->12->9)
//  step_pulse_o   out  1      1-cycle pulse per valid step
//  moving_o       out  1      last accepted pattern is non-zero
//  err_o          out  1      sticky: illegal transition or invalid pattern seen
//  stroke_done_o  out  1      1-cycle pulse when a full stroke completes
//  stroke_cnt_o   out  8      completed strokes, wraps 255->0
//  stall_o        out  1      watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, sync flops 0, accepted pattern 0000, stroke FSM OUT, exc=0.
//  Input path: 2-flop synchronizer -> stability counter; candidate accepted after STABLE_CYCLES equal samples.
//  Latency: new stable phase_i sampled at edge k -> step_pulse_o high in cycle following edge k+STABLE_CYCLES+2.
//  Valid set {0000,0011,0110,1100,1001}; other values -> err_o=1, accepted pattern unchanged.
//  Classification (prev accepted -> new accepted):
//   forward 3->6, 6->12, 12->9, 9->3: pos+1, dir_o=1, step pulse.
//   reverse 3->9, 9->12, 12->6, 6->3: pos-1, dir_o=0, step pulse.
//   jump 3<->12, 6<->9: err_o=1, no pos change, no pulse; new pattern becomes reference.
//   0000->valid: no step, moving_o=1. valid->0000: no step, moving_o=0. Same value: nothing.
//  pos_o wraps modulo 2^POS_W.
//  Stroke FSM (exc counter 0..STEPS_PER_STROKE):
//   OUT : step in OUT_DIR -> exc+1; opposite step -> exc-1 floored at 0.
//         exc reaches STEPS_PER_STROKE -> BACK.
//   BACK: step opposite to OUT_DIR -> exc-1; OUT_DIR step -> exc+1 saturated at STEPS_PER_STROKE.
//         exc reaches 0 -> stroke_done_o pulse in same cycle as step pulse, stroke_cnt_o+1, -> OUT.
//  clr_i: pos, exc, stroke_cnt, err, stall -> 0, FSM -> OUT.
//   Wins over simultaneous step; accepted pattern, dir, moving kept.
//  Reset mid-stroke: everything returns to reset values; next accepted non-zero pattern is reference only.
// CONFIGURATION
//  STEP_DEC_TIMEOUT_EN defined:
//   - Counter runs while moving_o=1; cleared on every step pulse or when moving_o=0.
//   - Reaching TIMEOUT_CYC sets stall_o (level) until next step, moving_o=0, clr_i or reset.
//  Undefined: no counter, stall_o tied 0.
// TESTING
//  T1 reset, then phase_i 0->3 held 10 cycles -> moving_o=1, no step_pulse_o, pos_o=0, err_o=0.
//  T2 3->6->12->9->3, each held 8 cycles -> 4 pulses, pos_o=4, dir_o=1.
//     Pulse cycle = edge sampling change + STABLE_CYCLES+2.
//  T3 3 then 1-cycle glitch 6 then back to 3 -> no pulse, pos unchanged.
//     Later 3->12 -> err_o=1 sticky, pos unchanged.
//  T4 100 steps dir 0 then 100 steps dir 1 -> single stroke_done_o pulse on 200th step, stroke_cnt_o=1, pos_o=0.
//  T5 50 out-leg steps, clr_i with simultaneous step -> pos_o=0, stroke_cnt_o=0, err_o=0.
//     Full stroke afterwards still needs 200 steps.
//  T6 (macro on, TIMEOUT_CYC=50) hold 3 for 60 cycles -> stall_o=1 by cycle 50+latency.
//     Next step clears it. Macro off: stall_o stays 0.

Source files
------------

// File: rtl/step_phase_decoder.sv
// Receive-side decoder for the two-phase stepper coil bus: glitch filter, step classification,
// signed position and cut-stroke counting. Optional stall watchdog under STEP_DEC_TIMEOUT_EN.
module step_phase_decoder #(
   parameter int STEPS_PER_STROKE = 100,
   parameter int POS_W            = 16,
   parameter int STABLE_CYCLES    = 4,
   parameter bit OUT_DIR          = 1'b0
`ifdef STEP_DEC_TIMEOUT_EN
   , parameter int TIMEOUT_CYC    = 2000000
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       phase_i,
   input  logic             clr_i,
   output logic [POS_W-1:0] pos_o,
   output logic             dir_o,
   output logic             step_pulse_o,
   output logic             moving_o,
   output logic             err_o,
   output logic             stroke_done_o,
   output logic [7:0]       stroke_cnt_o,
   output logic             stall_o
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int EXC_W = $clog2(STEPS_PER_STROKE + 1);

   typedef enum logic {ST_OUT, ST_BACK} stroke_t;

   logic [3:0]       r_sync1, r_sync2, r_cand, r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_used;
   logic [POS_W-1:0] r_pos;
   logic             r_dir, r_step_pulse, r_moving, r_err, r_stroke_done;
   logic [7:0]       r_stroke_cnt;
   logic [EXC_W-1:0] r_exc;
   stroke_t          r_state;

   logic       w_fire, w_valid, w_both_nz, w_step, w_jump, w_bad, w_fwd, w_with;
   logic [1:0] w_delta;

   function automatic logic [1:0] f_idx(input logic [3:0] p);
      case (p)
         4'b0110: f_idx = 2'd1;
         4'b1100: f_idx = 2'd2;
         4'b1001: f_idx = 2'd3;
         default: f_idx = 2'd0;
      endcase
   endfunction

   // A candidate is acted on once, on the cycle it first reaches the stability threshold.
   always_comb begin
      w_fire    = (r_cnt == CNT_W'(STABLE_CYCLES)) && !r_used && (r_cand != r_acc);
      w_valid   = (r_cand == 4'b0000) || (r_cand == 4'b0011) || (r_cand == 4'b0110) ||
                  (r_cand == 4'b1100) || (r_cand == 4'b1001);
      w_both_nz = (r_cand != 4'b0000) && (r_acc != 4'b0000);
      w_delta   = f_idx(r_cand) - f_idx(r_acc);
      w_fwd     = (w_delta == 2'd1);
      w_step    = w_fire && w_valid && w_both_nz && (w_delta[0] == 1'b1);
      w_jump    = w_fire && w_valid && w_both_nz && (w_delta == 2'd2);
      w_bad     = w_fire && !w_valid;
      w_with    = (w_fwd == OUT_DIR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_used  <= 1'b0;
      end else begin
         r_sync1 <= phase_i;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= CNT_W'(1);
            r_used <= 1'b0;
         end else begin
            if (r_cnt != CNT_W'(STABLE_CYCLES)) r_cnt <= r_cnt + CNT_W'(1);
            if (w_fire) r_used <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc         <= '0;
         r_pos         <= '0;
         r_dir         <= 1'b0;
         r_step_pulse  <= 1'b0;
         r_moving      <= 1'b0;
         r_err         <= 1'b0;
         r_stroke_done <= 1'b0;
         r_stroke_cnt  <= '0;
         r_exc         <= '0;
         r_state       <= ST_OUT;
      end else begin
         r_step_pulse  <= 1'b0;
         r_stroke_done <= 1'b0;
         if (w_fire && w_valid) begin
            r_acc    <= r_cand;
            r_moving <= (r_cand != 4'b0000);
         end
         if (clr_i) begin
            r_pos        <= '0;
            r_exc        <= '0;
            r_stroke_cnt <= '0;
            r_err        <= 1'b0;
            r_state      <= ST_OUT;
         end else begin
            if (w_bad || w_jump) r_err <= 1'b1;
            if (w_step) begin
               r_step_pulse <= 1'b1;
               r_dir        <= w_fwd;
               r_pos        <= w_fwd ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
               case (r_state)
                  ST_OUT: begin
                     if (w_with) begin
                        r_exc <= r_exc + EXC_W'(1);
                        if (r_exc == EXC_W'(STEPS_PER_STROKE - 1)) r_state <= ST_BACK;
                     end else if (r_exc != '0) begin
                        r_exc <= r_exc - EXC_W'(1);
                     end
                  end
                  ST_BACK: begin
                     if (!w_with) begin
                        r_exc <= r_exc - EXC_W'(1);
                        if (r_exc == EXC_W'(1)) begin
                           r_stroke_done <= 1'b1;
                           r_stroke_cnt  <= r_stroke_cnt + 8'd1;
                           r_state       <= ST_OUT;
                        end
                     end else if (r_exc != EXC_W'(STEPS_PER_STROKE)) begin
                        r_exc <= r_exc + EXC_W'(1);
                     end
                  end
                  default: r_state <= ST_OUT;
               endcase
            end
         end
      end
   end

`ifdef STEP_DEC_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo;
   logic             r_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tmo   <= '0;
         r_stall <= 1'b0;
      end else if (clr_i || !r_moving || w_step) begin
         r_tmo   <= '0;
         r_stall <= 1'b0;
      end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
         r_stall <= 1'b1;
      end else begin
         r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   assign stall_o = r_stall;
`else
   assign stall_o = 1'b0;
`endif

   assign pos_o         = r_pos;
   assign dir_o         = r_dir;
   assign step_pulse_o  = r_step_pulse;
   assign moving_o      = r_moving;
   assign err_o         = r_err;
   assign stroke_done_o = r_stroke_done;
   assign stroke_cnt_o  = r_stroke_cnt;

endmodule
